// File: rtl/ads1292_frame_parser.sv
// ADS1292 frame parser: collects a 9-byte frame (status, ch1, ch2), checks the
// status header and hands the sign-extended channel samples to a
// valid/ready consumer.
// Optional build macro: ADS1292_STATUS_CHECK_EN enables the 4'hC header
// check. Without it every frame is accepted and o_frame_err stays 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for i_frame_start
// COLLECT | shifting in frame bytes, counting up to 9
// CHECK   | one cycle: validate header, load outputs on success
// HOLD    | sample presented, waiting for i_ready
module ads1292_frame_parser #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_frame_start,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_ch1,
    output logic [OUT_W-1:0] o_ch2,
    output logic [23:0]      o_status,
    output logic             o_frame_err,
    output logic             o_frame_drop
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [71:0] r_shift;
    logic        r_valid;
    logic [OUT_W-1:0] r_ch1;
    logic [OUT_W-1:0] r_ch2;
    logic [23:0] r_status;
    logic        r_err;
    logic        r_drop;

    logic w_clr;
    logic w_shift_en;
    logic w_load;
    logic w_err;
    logic w_drop;
    logic w_hdr_ok;

`ifdef ADS1292_STATUS_CHECK_EN
    assign w_hdr_ok = (r_shift[71:68] == 4'hC);
`else
    // Header check disabled: w_err can never assert, so r_err stays 0.
    assign w_hdr_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_frame_start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A new frame start wins over a byte in the same cycle.
                if (i_frame_start) begin
                    w_clr = 1'b1;
                end else if (i_byte_valid) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == 4'd8) w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_drop = i_frame_start;
                if (w_hdr_ok) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_drop = i_frame_start;
                if (r_valid && i_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte counter and frame shift register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= 4'd0;
            r_shift <= 72'd0;
        end else begin
            if (w_clr)
                r_cnt <= 4'd0;
            else if (w_shift_en)
                r_cnt <= (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
            if (w_shift_en)
                r_shift <= {r_shift[63:0], i_byte};
        end
    end

    // Output sample registers, valid flag and event pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid  <= 1'b0;
            r_ch1    <= '0;
            r_ch2    <= '0;
            r_status <= 24'd0;
            r_err    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_err  <= w_err;
            r_drop <= w_drop;
            if (w_load) begin
                r_valid  <= 1'b1;
                r_status <= r_shift[71:48];
                r_ch1    <= OUT_W'($signed(r_shift[47:24]));
                r_ch2    <= OUT_W'($signed(r_shift[23:0]));
            end else if (r_state == ST_HOLD && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_ch1        = r_ch1;
    assign o_ch2        = r_ch2;
    assign o_status     = r_status;
    assign o_frame_err  = r_err;
    assign o_frame_drop = r_drop;

endmodule

// File: tb/tb_ads1292_frame_parser.sv
// Directed testbench for ads1292_frame_parser (32-bit and 24-bit instances).
module tb_ads1292_frame_parser;

    logic        clk;
    logic        rstn;
    logic        i_frame_start;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_ready;

    logic        o_valid;
    logic [31:0] o_ch1;
    logic [31:0] o_ch2;
    logic [23:0] o_status;
    logic        o_frame_err;
    logic        o_frame_drop;

    logic        v24;
    logic [23:0] ch1_24;
    logic [23:0] ch2_24;
    logic [23:0] st24;
    logic        err24;
    logic        drop24;

    int n_tests = 0;
    int n_fail  = 0;

    ads1292_frame_parser #(.OUT_W(32)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_frame_start(i_frame_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_ch1        (o_ch1),
        .o_ch2        (o_ch2),
        .o_status     (o_status),
        .o_frame_err  (o_frame_err),
        .o_frame_drop (o_frame_drop)
    );

    ads1292_frame_parser #(.OUT_W(24)) u_dut24 (
        .clk          (clk),
        .rstn         (rstn),
        .i_frame_start(i_frame_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_ready      (i_ready),
        .o_valid      (v24),
        .o_ch1        (ch1_24),
        .o_ch2        (ch2_24),
        .o_status     (st24),
        .o_frame_err  (err24),
        .o_frame_drop (drop24)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic pulse_start();
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] f);
        for (int i = 0; i < 9; i++) send_byte(f[71-8*i -: 8]);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_frame_start = 1'b0;
        i_byte = 8'h00;
        i_byte_valid = 1'b0;
        i_ready = 1'b1;
        #35;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", o_valid); end
        n_tests++; if (o_ch1 !== 32'h0) begin n_fail++; $display("FAIL reset_ch1 got %h want 0", o_ch1); end
        n_tests++; if (o_ch2 !== 32'h0) begin n_fail++; $display("FAIL reset_ch2 got %h want 0", o_ch2); end
        n_tests++; if (o_status !== 24'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", o_status); end
        n_tests++; if (o_frame_err !== 1'b0 || o_frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got err=%0b drop=%0b want 0", o_frame_err, o_frame_drop); end
        @(negedge clk);
        rstn = 1'b1;
        // i_ready with nothing held and stray bytes in IDLE do nothing
        send_byte(8'hC0);
        repeat (3) @(negedge clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_valid got %0b want 0", o_valid); end
    endtask

    task automatic test_basic();
        i_ready = 1'b1;
        pulse_start();
        send_frame(72'hC00000_000010_FFFFFE);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 got %0b want 0", o_valid); end
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", o_valid); end
        n_tests++; if (o_ch1 !== 32'h00000010) begin n_fail++; $display("FAIL basic_ch1 got %h want 00000010", o_ch1); end
        n_tests++; if (o_ch2 !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL basic_ch2 got %h want fffffffe", o_ch2); end
        n_tests++; if (o_status !== 24'hC00000) begin n_fail++; $display("FAIL basic_status got %h want c00000", o_status); end
        n_tests++; if (ch2_24 !== 24'hFFFFFE) begin n_fail++; $display("FAIL basic_ch2_w24 got %h want fffffe", ch2_24); end
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle got %0b want 0", o_valid); end
    endtask

    task automatic test_header();
        i_ready = 1'b1;
        pulse_start();
        send_frame(72'h800000_010203_040506);
        @(negedge clk);
`ifdef ADS1292_STATUS_CHECK_EN
        n_tests++; if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL hdr_err got %0b want 1", o_frame_err); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hdr_novalid got %0b want 0", o_valid); end
        @(negedge clk);
        n_tests++; if (o_frame_err !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL hdr_after got err=%0b valid=%0b want 0 0", o_frame_err, o_valid); end
`else
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL hdr_valid got %0b want 1", o_valid); end
        n_tests++; if (o_status !== 24'h800000) begin n_fail++; $display("FAIL hdr_status got %h want 800000", o_status); end
        n_tests++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL hdr_err_tied got %0b want 0", o_frame_err); end
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hdr_after got %0b want 0", o_valid); end
`endif
    endtask

    task automatic test_hold_drop();
        int xfers;
        i_ready = 1'b0;
        pulse_start();
        send_frame(72'hC0A5A5_123456_F00001);
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %0b want 1", o_valid); end
        repeat (4) @(negedge clk);
        pulse_start();
        n_tests++; if (o_frame_drop !== 1'b1) begin n_fail++; $display("FAIL hold_drop got %0b want 1", o_frame_drop); end
        send_byte(8'hEE);
        n_tests++; if (o_frame_drop !== 1'b0) begin n_fail++; $display("FAIL hold_drop_pulse got %0b want 0", o_frame_drop); end
        repeat (12) @(negedge clk);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_kept got %0b want 1", o_valid); end
        n_tests++; if (o_ch1 !== 32'h00123456) begin n_fail++; $display("FAIL hold_ch1 got %h want 00123456", o_ch1); end
        n_tests++; if (o_ch2 !== 32'hFFF00001) begin n_fail++; $display("FAIL hold_ch2 got %h want fff00001", o_ch2); end
        n_tests++; if (o_status !== 24'hC0A5A5) begin n_fail++; $display("FAIL hold_status got %h want c0a5a5", o_status); end
        i_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_valid === 1'b1) xfers++;
            @(negedge clk);
        end
        n_tests++; if (xfers !== 1) begin n_fail++; $display("FAIL hold_single_xfer got %0d want 1", xfers); end
    endtask

    task automatic test_abort();
        i_ready = 1'b1;
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        // restart with a byte in the same cycle; that byte must be discarded
        i_frame_start = 1'b1;
        i_byte        = 8'hAA;
        i_byte_valid  = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        i_byte_valid  = 1'b0;
        send_frame(72'hC00000_7FFFFF_800000);
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid got %0b want 1", o_valid); end
        n_tests++; if (o_ch1 !== 32'h007FFFFF) begin n_fail++; $display("FAIL abort_ch1 got %h want 007fffff", o_ch1); end
        n_tests++; if (o_ch2 !== 32'hFF800000) begin n_fail++; $display("FAIL abort_ch2 got %h want ff800000", o_ch2); end
        n_tests++; if (ch2_24 !== 24'h800000) begin n_fail++; $display("FAIL abort_ch2_w24 got %h want 800000", ch2_24); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int stray;
        i_ready = 1'b1;
        pulse_start();
        send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        rstn = 1'b0;
        #1;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %0b want 0", o_valid); end
        n_tests++; if (o_ch1 !== 32'h0 || o_ch2 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ch got %h %h want 0 0", o_ch1, o_ch2); end
        n_tests++; if (o_status !== 24'h0) begin n_fail++; $display("FAIL rst_mid_status got %h want 0", o_status); end
        @(negedge clk);
        rstn = 1'b1;
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h01);
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_valid !== 1'b0) stray++;
            @(negedge clk);
        end
        n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL rst_no_resume got %0d valid cycles want 0", stray); end
        pulse_start();
        send_frame(72'hC00000_000010_800001);
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_valid got %0b want 1", o_valid); end
        n_tests++; if (o_ch1 !== 32'h00000010) begin n_fail++; $display("FAIL rst_after_ch1 got %h want 00000010", o_ch1); end
        n_tests++; if (o_ch2 !== 32'hFF800001) begin n_fail++; $display("FAIL rst_after_ch2 got %h want ff800001", o_ch2); end
        n_tests++; if (ch2_24 !== 24'h800001) begin n_fail++; $display("FAIL w24_ch2 got %h want 800001", ch2_24); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_header();
        test_hold_drop();
        test_abort();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
